fp_sub_operand_stage: RTL
=========================

# fp_sub_operand_stage

Registered operand staging stage that sits directly upstream of the combinational FP64 subtractor. It accepts add/sub requests over a valid/ready handshake and converts add into subtract by flipping B's sign. It classifies the IEEE-754 double operands, resolves special cases (NaN, infinity, zero, subnormal) into a ready-made bypass result, and buffers requests in a small FIFO. The FIFO head drives the subtractor's A/B inputs.

## Interface
- DEPTH, 2: FIFO entries; power of two, at least 2.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  stage can accept a request
- in_op  in  1  0 = A−B, 1 = A+B
- in_a  in  64  operand A, IEEE-754 double
- in_b  in  64  operand B, IEEE-754 double
- out_valid  out  1  head entry present
- out_ready  in  1  consumer takes the head entry
- out_a  out  64  A for the subtractor; subnormal inputs flushed to signed zero
- out_b  out  64  effective B (sign flipped when in_op=1); subnormal flushed
- out_bypass  out  1  special case; the consumer uses out_bypass_result and ignores the subtractor
- out_bypass_result  out  64  special-case result
- out_invalid  out  1  invalid-operation flag for the head entry
- out_flushed  out  1  at least one subnormal input was flushed
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count < DEPTH). When full, no push occurs, even if a pop happens in the same cycle.
- out_valid = (count != 0). Outputs are read from the head storage entry, with no combinational path from the in_* inputs.
- Classification is done on the input side and the results are written into the entry.
- Effective B: b' = {in_b[63]^in_op, in_b[62:0]}.
- Operand classes (exponent e = bits[62:52], mantissa m = bits[51:0]):
  - NaN: e=2047, m≠0.
  - Inf: e=2047, m=0.
  - Zero: e=0, m=0.
  - Subnormal: e=0, m≠0. A subnormal is replaced by {sign, 63'b0} and sets flushed. It is then treated as Zero.
- Bypass priority, applied after flushing (first match wins):
  1. Either operand NaN → 64'h7FF8_0000_0000_0000, invalid=1.
  2. A Inf and b' Inf with equal signs → 64'h7FF8_0000_0000_0000, invalid=1.
  3. A Inf → A.
  4. b' Inf → {~b'[63], b'[62:0]}.
  5. A Zero and b' Zero → {A[63] & ~b'[63], 63'b0}.
  6. A Zero → {~b'[63], b'[62:0]}.
  7. b' Zero → A.
  8. Otherwise, out_bypass=0, out_bypass_result=0, invalid=0.
- Storage is a circular buffer with separate write and read pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- count is incremented on push-only, decremented on pop-only, and unchanged on simultaneous push and pop.
- A simultaneous push and pop with count=1 is legal. The new entry becomes head on the next cycle.
- A pop while out_valid=0 is ignored, regardless of out_ready.

## Timing
- Latency from accept to out_valid is 1 cycle when empty. Entry accepted at edge N, out_valid=1 after edge N.
- Throughput is 1 request per cycle while out_ready stays high.
- Head outputs stay stable while out_valid=1 & out_ready=0.
- Reset values:
  - count=0, pointers=0.
  - out_valid=0, in_ready=1.
  - All storage cleared, so out_a, out_b, out_bypass_result = 0 and out_bypass, out_invalid, out_flushed = 0.
- A reset asserted mid-operation discards all entries at that edge. A push presented in the same cycle is dropped.

## Test plan
- Reset, then push A=0x4008000000000000 (3.0), B=0x3FF0000000000000 (1.0), op=0, with out_ready=1 → out_valid one cycle later; out_a=0x4008000000000000, out_b=0x3FF0000000000000, out_bypass=0.
- Push op=1, A=1.0, B=0x4000000000000000 (2.0) → out_b=0xC000000000000000, out_bypass=0.
- A=0x7FF0000000000000 (+Inf), B=+Inf, op=0 → out_bypass=1, result 0x7FF8000000000000, out_invalid=1. With op=1 instead → result 0x7FF0000000000000, out_invalid=0.
- A=0x0000000000000001, B=0x8000000000000000, op=0 → out_flushed=1, out_bypass=1, result 0x0000000000000000. A=+0, B=5.0, op=0 → result 0xC014000000000000.
- Hold out_ready=0 and push 3 requests back-to-back → first two accepted, count=2, in_ready=0 on the third. Release out_ready → entries pop in order, pointers wrap, and the third is accepted once count<2.
- With count=1, push and pop in the same cycle → count stays 1 and the head becomes the new entry. Then assert rst with in_valid=1 → count=0, out_valid=0, and nothing appears afterward.

Source files
------------

// File: rtl/fp_sub_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_sub_operand_stage_if
// Brief    : Request/response bundle between the FP64 operand staging stage,
//            its upstream requester and the downstream subtractor/consumer.
// Revision : 1.0  initial release
// ============================================================================
interface fp_sub_operand_stage_if #(
    parameter int DEPTH = 2
);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    // Request side
    logic               in_valid;
    logic               in_ready;
    logic               in_op;
    logic [63:0]        in_a;
    logic [63:0]        in_b;

    // Head-entry side
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_a;
    logic [63:0]        out_b;
    logic               out_bypass;
    logic [63:0]        out_bypass_result;
    logic               out_invalid;
    logic               out_flushed;

    // Occupancy
    logic [c_cnt_w-1:0] count;

    // The staging stage itself
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_a, out_b, out_bypass,
               out_bypass_result, out_invalid, out_flushed, count
    );

    // Requester / consumer environment around the stage
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_bypass,
               out_bypass_result, out_invalid, out_flushed, count
    );
endinterface
`default_nettype wire

// File: rtl/fp_sub_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : fp_sub_operand_stage
// Brief    : Registered operand staging for the FP64 subtractor. Turns add
//            into subtract by flipping B's sign, flushes subnormals, resolves
//            IEEE-754 special cases into a bypass result and buffers requests
//            in a small circular FIFO whose head feeds the subtractor.
// Revision : 1.0  initial release
// ============================================================================
module fp_sub_operand_stage #(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_sub_operand_stage_if.slave bus
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);
    localparam logic [63:0]        c_qnan     = 64'h7FF8_0000_0000_0000;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        bypass;
        logic [63:0] result;
        logic        invalid;
        logic        flushed;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;

    // Operand fields; B is the effective (sign-adjusted) subtrahend
    logic [63:0]        w_b_eff;
    logic               w_a_exp_max, w_a_exp_zero, w_a_man_zero;
    logic               w_b_exp_max, w_b_exp_zero, w_b_man_zero;
    logic               w_a_nan, w_a_inf, w_a_sub, w_a_zero;
    logic               w_b_nan, w_b_inf, w_b_sub, w_b_zero;
    logic [63:0]        w_a_fl;
    logic [63:0]        w_b_fl;
    entry_t             w_entry;

    assign w_b_eff      = {bus.in_b[63] ^ bus.in_op, bus.in_b[62:0]};

    assign w_a_exp_max  = &bus.in_a[62:52];
    assign w_a_exp_zero = ~|bus.in_a[62:52];
    assign w_a_man_zero = ~|bus.in_a[51:0];
    assign w_b_exp_max  = &w_b_eff[62:52];
    assign w_b_exp_zero = ~|w_b_eff[62:52];
    assign w_b_man_zero = ~|w_b_eff[51:0];

    assign w_a_nan      = w_a_exp_max & ~w_a_man_zero;
    assign w_a_inf      = w_a_exp_max &  w_a_man_zero;
    assign w_a_sub      = w_a_exp_zero & ~w_a_man_zero;
    assign w_a_zero     = w_a_exp_zero;                 // subnormals count as zero once flushed
    assign w_b_nan      = w_b_exp_max & ~w_b_man_zero;
    assign w_b_inf      = w_b_exp_max &  w_b_man_zero;
    assign w_b_sub      = w_b_exp_zero & ~w_b_man_zero;
    assign w_b_zero     = w_b_exp_zero;

    assign w_a_fl       = w_a_sub ? {bus.in_a[63], 63'b0} : bus.in_a;
    assign w_b_fl       = w_b_sub ? {w_b_eff[63], 63'b0}  : w_b_eff;

    // Build the entry to store: flushed operands plus the prioritised bypass decision
    always_comb begin
        w_entry         = '0;
        w_entry.a       = w_a_fl;
        w_entry.b       = w_b_fl;
        w_entry.flushed = w_a_sub | w_b_sub;
        w_entry.bypass  = 1'b1;
        if (w_a_nan || w_b_nan) begin
            w_entry.result  = c_qnan;
            w_entry.invalid = 1'b1;
        end else if (w_a_inf && w_b_inf && (w_a_fl[63] == w_b_fl[63])) begin
            w_entry.result  = c_qnan;
            w_entry.invalid = 1'b1;
        end else if (w_a_inf) begin
            w_entry.result  = w_a_fl;
        end else if (w_b_inf) begin
            w_entry.result  = {~w_b_fl[63], w_b_fl[62:0]};
        end else if (w_a_zero && w_b_zero) begin
            w_entry.result  = {w_a_fl[63] & ~w_b_fl[63], 63'b0};
        end else if (w_a_zero) begin
            w_entry.result  = {~w_b_fl[63], w_b_fl[62:0]};
        end else if (w_b_zero) begin
            w_entry.result  = w_a_fl;
        end else begin
            w_entry.bypass  = 1'b0;
        end
    end

    assign w_in_ready  = (r_count < c_cnt_full);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    // Entry storage; reset clears every slot so the head outputs read zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready          = w_in_ready;
    assign bus.out_valid         = w_out_valid;
    assign bus.out_a             = r_mem[r_rd_ptr].a;
    assign bus.out_b             = r_mem[r_rd_ptr].b;
    assign bus.out_bypass        = r_mem[r_rd_ptr].bypass;
    assign bus.out_bypass_result = r_mem[r_rd_ptr].result;
    assign bus.out_invalid       = r_mem[r_rd_ptr].invalid;
    assign bus.out_flushed       = r_mem[r_rd_ptr].flushed;
    assign bus.count             = r_count;

endmodule
`default_nettype wire
